// File: rtl/prco_dbg_pkg.sv
// Shared definitions for the prco_core debug UART transmitter:
// FSM state encodings, line idle level, and the data width of a UART frame.
package prco_dbg_pkg;

    // Level of the serial line when no frame is being sent (mark state).
    localparam logic UART_IDLE_LVL = 1'b1;

    // Number of data bits carried in every frame.
    localparam int DATA_BITS = 8;

    // Transmitter FSM states. PARITY is only reachable in the 8E1 build.
    typedef enum logic [2:0] {
        DBG_IDLE   = 3'd0,
        DBG_START  = 3'd1,
        DBG_DATA   = 3'd2,
        DBG_PARITY = 3'd3,
        DBG_STOP   = 3'd4
    } dbg_state_t;

    // Even parity bit for a data byte: 1 when the byte holds an odd number of ones.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/prco_sync_fifo.sv
// Single-clock FIFO holding debug bytes waiting to be serialised.
// Full and empty are registered so that the consumer sees clean flags;
// pointers wrap naturally because DEPTH is a power of two (DEPTH == 2**AW).
module prco_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             do_push;
    logic             do_pop;
    logic             full_q;
    logic             empty_q;

    // Requests are ignored when they would overrun or underrun the storage.
    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;

    // The head entry is always visible so the consumer can load it in the pop cycle.
    assign dout  = mem[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

    // Occupancy after this cycle; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // Pointers, occupancy and the registered full/empty flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_FULL);
            empty_q <= (count_d == '0);
        end
    end

endmodule

// File: rtl/prco_debug_uart_tx.sv
// Debug trace transmitter for prco_core: captures q_debug on every instruction
// strobe, queues it, and sends each byte as a UART frame on q_tx.
// Build option: define PRCO_DBG_UART_PARITY_EN to add an even-parity bit (8E1);
// without it the frame is plain 8N1.
module prco_debug_uart_tx
    import prco_dbg_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16,
    parameter int FIFO_AW      = 4
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_en,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    input  logic       i_clr_ovf,
    output logic       q_tx,
    output logic       q_busy,
    output logic       q_full,
    output logic       q_overflow
);

    localparam int                BAUD_W   = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
    localparam int                BIT_W    = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

    dbg_state_t             state_q;
    dbg_state_t             state_d;
    logic [BAUD_W-1:0]      baud_q;
    logic [BIT_W-1:0]       bit_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic [DATA_BITS-1:0]   shreg_d;
    logic                   tx_q;
    logic                   tx_d;
    logic                   ovf_q;
    logic                   baud_done;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_drop;
    logic [DATA_BITS-1:0]   fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
`ifdef PRCO_DBG_UART_PARITY_EN
    logic                   parity_q;
`endif

    // Full is the registered flag, so a byte arriving while full is lost even if
    // the transmitter pops in the same cycle.
    assign fifo_push = i_valid && !fifo_full;
    assign fifo_drop = i_valid && fifo_full;

    // A new frame is only started from IDLE, and only while the transmitter is enabled.
    assign fifo_pop  = (state_q == DBG_IDLE) && i_en && !fifo_empty;

    assign baud_done = (baud_q == BAUD_MAX);

    prco_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (i_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= DBG_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: each non-idle state lasts whole bit-times counted by the baud counter.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DBG_IDLE: begin
                if (i_en && !fifo_empty) begin
                    state_d = DBG_START;
                end
            end
            DBG_START: begin
                if (baud_done) begin
                    state_d = DBG_DATA;
                end
            end
            DBG_DATA: begin
                if (baud_done && (bit_q == LAST_BIT)) begin
`ifdef PRCO_DBG_UART_PARITY_EN
                    state_d = DBG_PARITY;
`else
                    state_d = DBG_STOP;
`endif
                end
            end
`ifdef PRCO_DBG_UART_PARITY_EN
            DBG_PARITY: begin
                if (baud_done) begin
                    state_d = DBG_STOP;
                end
            end
`endif
            DBG_STOP: begin
                if (baud_done) begin
                    state_d = DBG_IDLE;
                end
            end
            default: state_d = DBG_IDLE;
        endcase
    end

    // Shift register: loaded with the head byte on pop, shifted right after each data bit.
    always_comb begin
        shreg_d = shreg_q;
        if (fifo_pop) begin
            shreg_d = fifo_dout;
        end else if ((state_q == DBG_DATA) && baud_done) begin
            shreg_d = {1'b0, shreg_q[DATA_BITS-1:1]};
        end
    end

    // Output logic: the line level for the state being entered, so the pin flop
    // changes on the same edge as the state.
    always_comb begin
        tx_d = UART_IDLE_LVL;
        case (state_d)
            DBG_START:  tx_d = ~UART_IDLE_LVL;
            DBG_DATA:   tx_d = shreg_d[0];
`ifdef PRCO_DBG_UART_PARITY_EN
            DBG_PARITY: tx_d = parity_q;
`endif
            default:    tx_d = UART_IDLE_LVL;
        endcase
    end

    // Baud counter, data-bit counter, shift register and the registered TX pin.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= UART_IDLE_LVL;
        end else begin
            if ((state_q == DBG_IDLE) || baud_done) begin
                baud_q <= '0;
            end else begin
                baud_q <= baud_q + 1'b1;
            end
            if (state_q != DBG_DATA) begin
                bit_q <= '0;
            end else if (baud_done) begin
                bit_q <= bit_q + 1'b1;
            end
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

`ifdef PRCO_DBG_UART_PARITY_EN
    // Parity is computed once from the whole byte when it leaves the FIFO.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            parity_q <= 1'b0;
        end else if (fifo_pop) begin
            parity_q <= even_parity(fifo_dout);
        end
    end
`endif

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ovf_q <= 1'b0;
        end else if (fifo_drop) begin
            ovf_q <= 1'b1;
        end else if (i_clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    assign q_tx       = tx_q;
    assign q_busy     = (state_q != DBG_IDLE) || !fifo_empty;
    assign q_full     = fifo_full;
    assign q_overflow = ovf_q;

endmodule

// File: tb/tb_prco_debug_uart_tx.sv
// Directed bench for prco_debug_uart_tx with CLKS_PER_BIT=4 and a 4-entry FIFO.
// Define PRCO_DBG_UART_PARITY_EN to exercise the 8E1 build.
module tb_prco_debug_uart_tx;

    localparam int CPB = 4;
`ifdef PRCO_DBG_UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = CPB * FRAME_BITS;

    logic       i_clk = 1'b0;
    logic       i_reset_n;
    logic       i_en;
    logic [7:0] i_data;
    logic       i_valid;
    logic       i_clr_ovf;
    logic       q_tx;
    logic       q_busy;
    logic       q_full;
    logic       q_overflow;

    int checks = 0;
    int errors = 0;
    int cycleCnt = 0;
    int startCycle = 0;

    prco_debug_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4),
        .FIFO_AW      (2)
    ) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_en       (i_en),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .i_clr_ovf  (i_clr_ovf),
        .q_tx       (q_tx),
        .q_busy     (q_busy),
        .q_full     (q_full),
        .q_overflow (q_overflow)
    );

    // Free-running 100 MHz clock.
    always #5 i_clk = ~i_clk;

    // Cycle counter used to time frame starts.
    always @(posedge i_clk) cycleCnt <= cycleCnt + 1;

    // Absolute time limit so the bench can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Push one byte: called at a negedge, strobe is sampled at the following posedge.
    task automatic applyStimulus(input logic [7:0] data);
        i_data  = data;
        i_valid = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic waitForStart(output bit found);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge i_clk);
            if (q_tx == 1'b0) begin
                found = 1'b1;
                startCycle = cycleCnt;
                break;
            end
        end
        if (!found) checkOutput("start_timeout", 32'd0, 32'd1);
    endtask

    task automatic watchLine(input int n, output bit sawLow);
        sawLow = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            if (q_tx == 1'b0) sawLow = 1'b1;
        end
    endtask

    // Sample one frame mid-bit; optionally drop i_en while bit dropEnAt is on the line.
    task automatic captureFrame(input int dropEnAt, output logic [7:0] data, output logic par);
        bit          found;
        logic [10:0] bits;
        bits = '1;
        waitForStart(found);
        if (!found) begin
            data = 8'h00;
            par  = 1'b0;
            return;
        end
        for (int k = 0; k < FRAME_BITS; k++) begin
            repeat ((k == 0) ? 1 : CPB) @(negedge i_clk);
            bits[k] = q_tx;
            if (k == dropEnAt) i_en = 1'b0;
        end
        checkOutput("frame_start_bit", {31'd0, bits[0]}, 32'd0);
        checkOutput("frame_stop_bit", {31'd0, bits[FRAME_BITS-1]}, 32'd1);
        data = bits[8:1];
        par  = bits[9];
    endtask

    initial begin
        logic [10:0] expBits;
        logic [7:0]  d;
        logic        p;
        bit          sawLow;
        bit          found;
        int          prevStart;
        int          gap;

        i_reset_n = 1'b0;
        i_en      = 1'b0;
        i_valid   = 1'b0;
        i_data    = 8'h00;
        i_clr_ovf = 1'b0;

        // Reset values
        #12;
        checkOutput("rst_tx", {31'd0, q_tx}, 32'd1);
        checkOutput("rst_busy", {31'd0, q_busy}, 32'd0);
        checkOutput("rst_full", {31'd0, q_full}, 32'd0);
        checkOutput("rst_ovf", {31'd0, q_overflow}, 32'd0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(negedge i_clk);

        // Test 1: single 0xA5 frame with exact timing
        $display("[TB] test 1: single frame 0xA5");
`ifdef PRCO_DBG_UART_PARITY_EN
        expBits = 11'b10101001010;
`else
        expBits = 11'b01101001010;
`endif
        i_en = 1'b1;
        applyStimulus(8'hA5);
        checkOutput("t1_tx_after_push", {31'd0, q_tx}, 32'd1);
        checkOutput("t1_busy_after_push", {31'd0, q_busy}, 32'd1);
        @(negedge i_clk);
        checkOutput("t1_tx_fall", {31'd0, q_tx}, 32'd0);
        for (int k = 0; k < FRAME_BITS; k++) begin
            repeat ((k == 0) ? 1 : CPB) @(negedge i_clk);
            checkOutput($sformatf("t1_bit%0d", k), {31'd0, q_tx}, {31'd0, expBits[k]});
        end
        repeat (2) @(negedge i_clk);
        checkOutput("t1_busy_last_cycle", {31'd0, q_busy}, 32'd1);
        @(negedge i_clk);
        checkOutput("t1_busy_done", {31'd0, q_busy}, 32'd0);
        checkOutput("t1_tx_idle", {31'd0, q_tx}, 32'd1);
        repeat (3) @(negedge i_clk);

        // Test 2: three back-to-back frames
        $display("[TB] test 2: back-to-back frames");
        prevStart = 0;
        fork
            begin
                applyStimulus(8'h01);
                applyStimulus(8'h02);
                applyStimulus(8'h03);
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    captureFrame(-1, d, p);
                    checkOutput($sformatf("t2_data%0d", i), {24'd0, d}, 32'(i + 1));
                    if (i > 0) begin
                        gap = startCycle - prevStart;
                        checkOutput($sformatf("t2_gap%0d", i),
                                    {31'd0, (gap >= FRAME_CYC) && (gap <= FRAME_CYC + 1)}, 32'd1);
                    end
                    prevStart = startCycle;
                end
            end
        join
        i_en = 1'b0;
        repeat (10) @(negedge i_clk);

        // Test 3: fill, overflow, clear, drain
        $display("[TB] test 3: full and overflow");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'h10 + 8'(i));
            checkOutput($sformatf("t3_full%0d", i), {31'd0, q_full}, (i >= 3) ? 32'd1 : 32'd0);
            checkOutput($sformatf("t3_ovf%0d", i), {31'd0, q_overflow}, (i == 4) ? 32'd1 : 32'd0);
        end
        checkOutput("t3_tx_held", {31'd0, q_tx}, 32'd1);
        i_data    = 8'h99;
        i_valid   = 1'b1;
        i_clr_ovf = 1'b1;
        @(negedge i_clk);
        i_valid   = 1'b0;
        i_clr_ovf = 1'b0;
        checkOutput("t3_drop_beats_clear", {31'd0, q_overflow}, 32'd1);
        i_clr_ovf = 1'b1;
        @(negedge i_clk);
        i_clr_ovf = 1'b0;
        checkOutput("t3_ovf_cleared", {31'd0, q_overflow}, 32'd0);
        i_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            captureFrame(-1, d, p);
            checkOutput($sformatf("t3_data%0d", i), {24'd0, d}, 32'h10 + 32'(i));
        end
        watchLine(3 * FRAME_CYC, sawLow);
        checkOutput("t3_no_fifth_frame", {31'd0, sawLow}, 32'd0);
        checkOutput("t3_busy_drained", {31'd0, q_busy}, 32'd0);

        // Test 4: disable mid-frame with a byte still queued
        $display("[TB] test 4: enable gating");
        fork
            begin
                applyStimulus(8'h3C);
                applyStimulus(8'h5A);
            end
            captureFrame(3, d, p);
        join
        checkOutput("t4_frame1", {24'd0, d}, 32'h3C);
        watchLine(3 * FRAME_CYC, sawLow);
        checkOutput("t4_held_idle", {31'd0, sawLow}, 32'd0);
        checkOutput("t4_busy_queued", {31'd0, q_busy}, 32'd1);
        i_en = 1'b1;
        captureFrame(-1, d, p);
        checkOutput("t4_frame2", {24'd0, d}, 32'h5A);
        watchLine(FRAME_CYC, sawLow);

        // Test 5: asynchronous reset during a data bit
        $display("[TB] test 5: async reset mid-frame");
        fork
            begin
                applyStimulus(8'h00);
                applyStimulus(8'h81);
            end
            waitForStart(found);
        join
        checkOutput("t5_start_seen", {31'd0, found}, 32'd1);
        repeat (10) @(negedge i_clk);
        checkOutput("t5_tx_low_data", {31'd0, q_tx}, 32'd0);
        #2;
        i_reset_n = 1'b0;
        #1;
        checkOutput("t5_tx_async", {31'd0, q_tx}, 32'd1);
        checkOutput("t5_busy_async", {31'd0, q_busy}, 32'd0);
        checkOutput("t5_full_async", {31'd0, q_full}, 32'd0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        watchLine(3 * FRAME_CYC, sawLow);
        checkOutput("t5_no_frame", {31'd0, sawLow}, 32'd0);
        checkOutput("t5_busy_after", {31'd0, q_busy}, 32'd0);

`ifdef PRCO_DBG_UART_PARITY_EN
        // Test 6: parity bit values
        $display("[TB] test 6: even parity");
        fork
            applyStimulus(8'hA5);
            captureFrame(-1, d, p);
        join
        checkOutput("t6_data_a5", {24'd0, d}, 32'hA5);
        checkOutput("t6_par_a5", {31'd0, p}, 32'd0);
        watchLine(4, sawLow);
        fork
            applyStimulus(8'h07);
            captureFrame(-1, d, p);
        join
        checkOutput("t6_data_07", {24'd0, d}, 32'h07);
        checkOutput("t6_par_07", {31'd0, p}, 32'd1);
        watchLine(FRAME_CYC, sawLow);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
